// File: rtl/face_detect_pkg.sv
// Shared types and constants for the Haar cascade scheduler.
// Provides the scheduler FSM encoding, stage identifiers and saturation limits.
// Pure declarations; no logic, no latency, no flow control.
package face_detect_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4
  } sched_state_e;

  // Stage identifiers; STAGE_NONE marks a window that cleared every stage.
  localparam logic [1:0] STAGE_FIRST  = 2'd0;
  localparam logic [1:0] STAGE_SECOND = 2'd1;
  localparam logic [1:0] STAGE_THIRD  = 2'd2;
  localparam logic [1:0] STAGE_NONE   = 2'd3;

  localparam int NUM_STAGES = 3;

  // Default accumulator width and its signed saturation limits.
  localparam int ACC_WIDTH_DEF = 16;
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/cascade_stage_scheduler_sat_accumulator.sv
// Signed saturating accumulator with synchronous clear and add-enable.
// Latency: result visible the cycle after en; clear has priority over en.
// Backpressure: none; the caller decides when to add.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - zero the accumulator
//   en        - add addend this cycle
//   addend    - signed value to add
//   acc       - current accumulated value, clamped to the signed range
module sat_accumulator
  import face_detect_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [ACC_WIDTH-1:0] addend,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0]          sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_sat;

  // One guard bit: overflow shows up as the two top bits disagreeing,
  // and the guard bit then tells the direction.
  always_comb begin
    sum_wide = {acc[ACC_WIDTH-1], acc} + {addend[ACC_WIDTH-1], addend};
    sum_sat  = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sum_sat = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_sat;
    end
  end

endmodule

// File: rtl/cascade_stage_scheduler.sv
// Sequences the three-stage Haar cascade over one window and reports a verdict.
// Latency: 2 cycles per classifier (1-cycle eval) + 1 per stage check + 1 report.
// Backpressure: window accepted only in IDLE; source holds i_window_valid.
//
// Optional feature macro: CASCADE_EVAL_TIMEOUT_EN (adds TIMEOUT_CYCLES watchdog
// and the o_timeout port).
//
// Ports:
//   clk_fpga, reset_fpga                  - clock, synchronous active-high reset
//   i_window_valid / o_window_ready       - window handshake, i_xcoord/i_ycoord
//   o_stage_sel, o_classifier_index       - classifier address to the datapath
//   o_eval_start / i_eval_done            - evaluation request / result strobe
//   i_eval_score, i_stage_threshold       - signed score and stage threshold
//   o_candidate_valid, o_is_candidate,
//   o_reject_stage, o_xcoord, o_ycoord    - verdict strobe and held verdict
//   o_busy                                - window in progress
//   o_timeout                             - watchdog abort (feature builds only)
module cascade_stage_scheduler
  import face_detect_pkg::*;
#(
  parameter int DATA_WIDTH_12                = 12,
  parameter int ACC_WIDTH                    = 16,
  parameter int NUM_CLASSIFIERS_FIRST_STAGE  = 10,
  parameter int NUM_CLASSIFIERS_SECOND_STAGE = 10,
  parameter int NUM_CLASSIFIERS_THIRD_STAGE  = 10,
  parameter int INDEX_WIDTH                  = 8
`ifdef CASCADE_EVAL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES               = 255
`endif
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_window_valid,
  output logic                     o_window_ready,
  input  logic [DATA_WIDTH_12-1:0] i_xcoord,
  input  logic [DATA_WIDTH_12-1:0] i_ycoord,
  output logic [1:0]               o_stage_sel,
  output logic [INDEX_WIDTH-1:0]   o_classifier_index,
  output logic                     o_eval_start,
  input  logic                     i_eval_done,
  input  logic [ACC_WIDTH-1:0]     i_eval_score,
  input  logic [ACC_WIDTH-1:0]     i_stage_threshold,
  output logic                     o_candidate_valid,
  output logic                     o_is_candidate,
  output logic [1:0]               o_reject_stage,
  output logic [DATA_WIDTH_12-1:0] o_xcoord,
  output logic [DATA_WIDTH_12-1:0] o_ycoord,
  output logic                     o_busy
`ifdef CASCADE_EVAL_TIMEOUT_EN
  ,
  output logic                     o_timeout
`endif
);

  sched_state_e state_q, state_d;

  logic [1:0]               stage_q;
  logic [INDEX_WIDTH-1:0]   idx_q;
  logic [INDEX_WIDTH-1:0]   last_idx;
  logic [DATA_WIDTH_12-1:0] win_x_q, win_y_q;
  logic                     is_cand_q;
  logic [1:0]               reject_q;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        stage_pass;

  // Control strobes from the FSM to the datapath.
  logic       accept;
  logic       acc_clr;
  logic       acc_en;
  logic       idx_inc;
  logic       stage_adv;
  logic       report_load;
  logic       verdict_d;
  logic [1:0] reject_d;

`ifdef CASCADE_EVAL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit;
  logic             timeout_d;
  logic             timeout_q;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Last classifier index of the stage being evaluated.
  always_comb begin
    case (stage_q)
      STAGE_FIRST:  last_idx = INDEX_WIDTH'(NUM_CLASSIFIERS_FIRST_STAGE - 1);
      STAGE_SECOND: last_idx = INDEX_WIDTH'(NUM_CLASSIFIERS_SECOND_STAGE - 1);
      default:      last_idx = INDEX_WIDTH'(NUM_CLASSIFIERS_THIRD_STAGE - 1);
    endcase
  end

  // Threshold comes combinationally from the ROM addressed by o_stage_sel.
  assign stage_pass = (acc >= $signed(i_stage_threshold));

  sat_accumulator #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk    (clk_fpga),
    .rst    (reset_fpga),
    .clr    (acc_clr),
    .en     (acc_en),
    .addend (i_eval_score),
    .acc    (acc)
  );

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    idx_inc     = 1'b0;
    stage_adv   = 1'b0;
    report_load = 1'b0;
    verdict_d   = 1'b0;
    reject_d    = stage_q;
`ifdef CASCADE_EVAL_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_window_valid) begin
          accept  = 1'b1;
          acc_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the watchdog's final cycle still counts.
        if (i_eval_done) begin
          acc_en = 1'b1;
          if (idx_q == last_idx) begin
            state_d = ST_CHECK;
          end else begin
            idx_inc = 1'b1;
            state_d = ST_ISSUE;
          end
        end
`ifdef CASCADE_EVAL_TIMEOUT_EN
        else if (tmo_hit) begin
          report_load = 1'b1;
          timeout_d   = 1'b1;
          state_d     = ST_REPORT;
        end
`endif
      end
      ST_CHECK: begin
        if (!stage_pass) begin
          report_load = 1'b1;
          state_d     = ST_REPORT;
        end else if (stage_q == 2'(NUM_STAGES - 1)) begin
          report_load = 1'b1;
          verdict_d   = 1'b1;
          reject_d    = STAGE_NONE;
          state_d     = ST_REPORT;
        end else begin
          stage_adv = 1'b1;
          acc_clr   = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Window working registers: coordinates captured at acceptance, stage and
  // index walk the cascade.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      stage_q <= STAGE_FIRST;
      idx_q   <= '0;
      win_x_q <= '0;
      win_y_q <= '0;
    end else if (accept) begin
      stage_q <= STAGE_FIRST;
      idx_q   <= '0;
      win_x_q <= i_xcoord;
      win_y_q <= i_ycoord;
    end else if (stage_adv) begin
      stage_q <= stage_q + 2'd1;
      idx_q   <= '0;
    end else if (idx_inc) begin
      idx_q <= idx_q + INDEX_WIDTH'(1);
    end
  end

  // Reported verdict and coordinates are a separate copy so a newly accepted
  // window does not disturb what the previous strobe published.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      is_cand_q <= 1'b0;
      reject_q  <= STAGE_NONE;
      o_xcoord  <= '0;
      o_ycoord  <= '0;
    end else if (report_load) begin
      is_cand_q <= verdict_d;
      reject_q  <= reject_d;
      o_xcoord  <= win_x_q;
      o_ycoord  <= win_y_q;
    end
  end

`ifdef CASCADE_EVAL_TIMEOUT_EN
  // Watchdog counts WAIT cycles for the current evaluation only.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
      if (report_load) begin
        timeout_q <= timeout_d;
      end
    end
  end

  assign o_timeout = timeout_q && (state_q == ST_REPORT);
`endif

  assign o_window_ready     = (state_q == ST_IDLE);
  assign o_busy             = (state_q != ST_IDLE);
  assign o_eval_start       = (state_q == ST_ISSUE);
  assign o_candidate_valid  = (state_q == ST_REPORT);
  assign o_stage_sel        = stage_q;
  assign o_classifier_index = idx_q;
  assign o_is_candidate     = is_cand_q;
  assign o_reject_stage     = reject_q;

endmodule

// File: tb/tb_cascade_stage_scheduler.sv
// Scoreboard bench for cascade_stage_scheduler: per-window expectations come
// from an arithmetic model of the cascade, a responder plays the classifier
// datapath, and a monitor checks every verdict strobe.
module tb_cascade_stage_scheduler;

  localparam int DW  = 12;
  localparam int AW  = 16;
  localparam int N0  = 10;
  localparam int N1  = 10;
  localparam int N2  = 10;
  localparam int IW  = 8;
  localparam int TMO = 255;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga;
  logic          i_window_valid;
  logic          o_window_ready;
  logic [DW-1:0] i_xcoord, i_ycoord;
  logic [1:0]    o_stage_sel;
  logic [IW-1:0] o_classifier_index;
  logic          o_eval_start;
  logic          i_eval_done;
  logic [AW-1:0] i_eval_score;
  logic [AW-1:0] i_stage_threshold;
  logic          o_candidate_valid;
  logic          o_is_candidate;
  logic [1:0]    o_reject_stage;
  logic [DW-1:0] o_xcoord, o_ycoord;
  logic          o_busy;
`ifdef CASCADE_EVAL_TIMEOUT_EN
  logic          o_timeout;
`endif

  always #5 clk_fpga = ~clk_fpga;

  cascade_stage_scheduler #(
    .DATA_WIDTH_12                (DW),
    .ACC_WIDTH                    (AW),
    .NUM_CLASSIFIERS_FIRST_STAGE  (N0),
    .NUM_CLASSIFIERS_SECOND_STAGE (N1),
    .NUM_CLASSIFIERS_THIRD_STAGE  (N2),
    .INDEX_WIDTH                  (IW)
  ) dut (
    .clk_fpga           (clk_fpga),
    .reset_fpga         (reset_fpga),
    .i_window_valid     (i_window_valid),
    .o_window_ready     (o_window_ready),
    .i_xcoord           (i_xcoord),
    .i_ycoord           (i_ycoord),
    .o_stage_sel        (o_stage_sel),
    .o_classifier_index (o_classifier_index),
    .o_eval_start       (o_eval_start),
    .i_eval_done        (i_eval_done),
    .i_eval_score       (i_eval_score),
    .i_stage_threshold  (i_stage_threshold),
    .o_candidate_valid  (o_candidate_valid),
    .o_is_candidate     (o_is_candidate),
    .o_reject_stage     (o_reject_stage),
    .o_xcoord           (o_xcoord),
    .o_ycoord           (o_ycoord),
    .o_busy             (o_busy)
`ifdef CASCADE_EVAL_TIMEOUT_EN
    ,
    .o_timeout          (o_timeout)
`endif
  );

  typedef struct {
    int cand;
    int rej;
    int x;
    int y;
    int starts;
    int lat;
    int tmo;
  } exp_t;

  exp_t expq[$];
  int   evq[$];

  int sc[3][10];
  int dl[3][10];
  int thr_tab[3];
  bit no_done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int accept_cyc = 0;
  int starts_cnt = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Threshold ROM, indexed by the stage the DUT currently selects.
  always_comb begin
    case (o_stage_sel)
      2'd0:    i_stage_threshold = AW'(thr_tab[0]);
      2'd1:    i_stage_threshold = AW'(thr_tab[1]);
      2'd2:    i_stage_threshold = AW'(thr_tab[2]);
      default: i_stage_threshold = '0;
    endcase
  end

  always @(posedge clk_fpga) cyc <= cyc + 1;

  // Reference cascade: per stage, saturating sum of scores vs. threshold.
  // Each classifier costs one issue cycle plus its result delay; each
  // evaluated stage costs one compare cycle; the report costs one more.
  task automatic model(input int x, input int y, output exp_t e);
    int acc;
    int n[3];
    n = '{N0, N1, N2};
    e.cand = 1; e.rej = 3; e.x = x; e.y = y; e.starts = 0; e.lat = 1; e.tmo = 0;
    if (no_done) begin
      e.cand = 0; e.rej = 0; e.starts = 1; e.lat = 2 + TMO; e.tmo = 1;
      evq.push_back(0);
      return;
    end
    for (int s = 0; s < 3; s++) begin
      acc = 0;
      for (int i = 0; i < n[s]; i++) begin
        acc = acc + sc[s][i];
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        e.starts++;
        e.lat += 1 + dl[s][i];
        evq.push_back(s * 256 + i);
      end
      e.lat += 1;
      if (acc < thr_tab[s]) begin
        e.cand = 0;
        e.rej = s;
        return;
      end
    end
  endtask

  // Classifier datapath stand-in.
  initial begin
    int s, i, d, want;
    i_eval_done  = 1'b0;
    i_eval_score = '0;
    forever begin
      @(negedge clk_fpga);
      if (o_eval_start && !reset_fpga) begin
        s = int'(o_stage_sel);
        i = int'(o_classifier_index);
        if (evq.size() == 0) begin
          chk("unexpected_eval_start", s * 256 + i, -1);
        end else begin
          want = evq.pop_front();
          chk("eval_stage_index", s * 256 + i, want);
        end
        if (s > 2 || i > 9) begin s = 0; i = 0; end
        d = dl[s][i];
        if (!no_done) begin
          repeat (d) @(posedge clk_fpga);
          #1;
          i_eval_done  = 1'b1;
          i_eval_score = AW'(sc[s][i]);
          @(posedge clk_fpga);
          #1;
          i_eval_done  = 1'b0;
          i_eval_score = '0;
        end
      end
    end
  end

  // Monitor: verdict strobes against the scoreboard.
  always @(negedge clk_fpga) begin
    exp_t e;
    if (!reset_fpga) begin
      if (o_eval_start) starts_cnt++;
      if (o_candidate_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("is_candidate", int'(o_is_candidate), e.cand);
          chk("reject_stage", int'(o_reject_stage), e.rej);
          chk("xcoord", int'(o_xcoord), e.x);
          chk("ycoord", int'(o_ycoord), e.y);
          chk("eval_start_count", starts_cnt, e.starts);
          chk("strobe_latency", cyc - accept_cyc, e.lat);
`ifdef CASCADE_EVAL_TIMEOUT_EN
          chk("timeout_flag", int'(o_timeout), e.tmo);
`endif
        end
        last_strobe_cyc = cyc;
        strobe_cnt++;
      end
      if (i_window_valid && o_window_ready) begin
        accept_cyc = cyc;
        starts_cnt = 0;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_accept(input int x, input int y, input bit drop, output int acc_c);
    int guard;
    guard = 0;
    i_window_valid = 1'b1;
    i_xcoord = DW'(x);
    i_ycoord = DW'(y);
    @(negedge clk_fpga);
    while (!o_window_ready && guard < 1000) begin
      @(negedge clk_fpga);
      guard++;
    end
    if (guard >= 1000) chk("accept_wait_bound", guard, 0);
    acc_c = cyc;
    @(posedge clk_fpga);
    #1;
    if (drop) i_window_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target);
    int guard;
    guard = 0;
    while (strobe_cnt < target && guard < 3000) begin
      @(posedge clk_fpga);
      guard++;
    end
    if (strobe_cnt < target) chk("strobe_wait_bound", strobe_cnt, target);
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic run_window(input int x, input int y);
    exp_t e;
    int   tgt, ac;
    model(x, y, e);
    expq.push_back(e);
    tgt = strobe_cnt + 1;
    drive_accept(x, y, 1'b1, ac);
    wait_strobes(tgt);
  endtask

  task automatic fill(input int s, input int score, input int thr, input int delay);
    for (int i = 0; i < 10; i++) begin
      sc[s][i] = score;
      dl[s][i] = delay;
    end
    thr_tab[s] = thr;
  endtask

  initial begin
    exp_t e;
    int   ac, tgt, guard, busy_seen;

    reset_fpga     = 1'b1;
    i_window_valid = 1'b0;
    i_xcoord       = '0;
    i_ycoord       = '0;
    for (int s = 0; s < 3; s++) fill(s, 5, 50, 1);

    repeat (2) @(posedge clk_fpga);
    @(negedge clk_fpga);
    chk("reset_window_ready", int'(o_window_ready), 1);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_candidate_valid", int'(o_candidate_valid), 0);
    chk("reset_eval_start", int'(o_eval_start), 0);
    chk("reset_is_candidate", int'(o_is_candidate), 0);
    chk("reset_reject_stage", int'(o_reject_stage), 3);
    chk("reset_xcoord", int'(o_xcoord), 0);
    chk("reset_ycoord", int'(o_ycoord), 0);
    chk("reset_stage_sel", int'(o_stage_sel), 0);
    chk("reset_index", int'(o_classifier_index), 0);
    @(posedge clk_fpga);
    #1;
    reset_fpga = 1'b0;

    // Full pass, 1-cycle results: 64-cycle latency, 30 evaluations.
    run_window(12, 34);

    // Stage-1 rejection.
    fill(1, 1, 50, 1);
    run_window(100, 200);

    // Positive saturation reaching the maximum threshold.
    fill(0, 32767, 32767, 1);
    fill(1, 5, 50, 1);
    run_window(4095, 1);

    // Negative saturation just below the threshold; a wrap would pass.
    fill(0, -32768, -32767, 2);
    run_window(0, 4095);

    // Back-to-back windows with valid held high.
    for (int s = 0; s < 3; s++) fill(s, 5, 50, 1);
    model(321, 654, e); expq.push_back(e);
    model(777, 888, e); expq.push_back(e);
    tgt = strobe_cnt + 2;
    @(posedge clk_fpga); #1;
    drive_accept(321, 654, 1'b0, ac);
    drive_accept(777, 888, 1'b1, ac);
    chk("b2b_accept_after_strobe", ac - last_strobe_cyc, 1);
    wait_strobes(tgt);

    // Reset while waiting on a stage-1 evaluation; the late result is dropped.
    for (int s = 0; s < 3; s++) fill(s, 5, 50, 3);
    model(7, 9, e);
    @(posedge clk_fpga); #1;
    drive_accept(7, 9, 1'b1, ac);
    guard = 0;
    @(negedge clk_fpga);
    while (!(o_eval_start && o_stage_sel == 2'd1) && guard < 2000) begin
      @(negedge clk_fpga);
      guard++;
    end
    chk("reset_test_reached_stage1", int'(guard < 2000), 1);
    @(posedge clk_fpga); #1;
    reset_fpga = 1'b1;
    @(posedge clk_fpga); #1;
    reset_fpga = 1'b0;
    evq.delete();
    @(negedge clk_fpga);
    chk("midreset_ready", int'(o_window_ready), 1);
    chk("midreset_busy", int'(o_busy), 0);
    chk("midreset_stage_sel", int'(o_stage_sel), 0);
    chk("midreset_reject_stage", int'(o_reject_stage), 3);
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk_fpga);
      if (o_busy || o_candidate_valid || o_eval_start) busy_seen++;
    end
    chk("midreset_stays_idle", busy_seen, 0);
    @(posedge clk_fpga); #1;

    // Randomized windows.
    for (int w = 0; w < 20; w++) begin
      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < 10; i++) begin
          sc[s][i] = int'($urandom_range(0, 20)) - 8;
          if ($urandom_range(0, 15) == 0) sc[s][i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
          dl[s][i] = int'($urandom_range(1, 3));
        end
        thr_tab[s] = int'($urandom_range(0, 80)) - 20;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_fpga);
      #1;
      run_window(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end

`ifdef CASCADE_EVAL_TIMEOUT_EN
    // Datapath never answers: watchdog aborts at stage 0.
    for (int s = 0; s < 3; s++) fill(s, 5, 50, 1);
    no_done = 1'b1;
    run_window(55, 66);
    no_done = 1'b0;
`endif

    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got %0d cycles, expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cascade_stage_scheduler.md
Name: cascade_stage_scheduler

Overview:
Sequences the three-stage Haar cascade over one integral-image window at a time.
- Accepts a window (with its scaled coordinates) from the integral-image memory via valid/ready.
- Issues one classifier evaluation at a time to the classifier datapath and accumulates the returned scores.
- Compares each stage sum against that stage's threshold, exits early on rejection, and reports a candidate/non-candidate verdict per window.
- Sits between the integral-image memory/resize path and the primary_stage_classifier evaluation datapath.

Parameters:
DATA_WIDTH_12, 12, coordinate width
ACC_WIDTH, 16, signed score/accumulator/threshold width
NUM_CLASSIFIERS_FIRST_STAGE, 10, classifiers in stage 0 (must be >=1)
NUM_CLASSIFIERS_SECOND_STAGE, 10, classifiers in stage 1 (must be >=1)
NUM_CLASSIFIERS_THIRD_STAGE, 10, classifiers in stage 2 (must be >=1)
INDEX_WIDTH, 8, classifier index width
TIMEOUT_CYCLES, 255, evaluation watchdog limit (used only with the optional feature)

Ports:
clk_fpga  in  1  system clock
reset_fpga  in  1  synchronous, active-high reset
i_window_valid  in  1  new window available
o_window_ready  out  1  scheduler can accept a window
i_xcoord  in  DATA_WIDTH_12  window x (scaled)
i_ycoord  in  DATA_WIDTH_12  window y (scaled)
o_stage_sel  out  2  current stage (0..2), selects the ROM
o_classifier_index  out  INDEX_WIDTH  classifier index within the stage
o_eval_start  out  1  one-cycle evaluation request
i_eval_done  in  1  evaluation result valid
i_eval_score  in  ACC_WIDTH  signed classifier score
i_stage_threshold  in  ACC_WIDTH  signed threshold for o_stage_sel (combinational from ROM)
o_candidate_valid  out  1  one-cycle verdict strobe
o_is_candidate  out  1  verdict, qualified by o_candidate_valid
o_reject_stage  out  2  stage that rejected the window (3 = passed)
o_xcoord  out  DATA_WIDTH_12  latched window x
o_ycoord  out  DATA_WIDTH_12  latched window y
o_busy  out  1  window in progress
o_timeout  out  1  present only with CASCADE_EVAL_TIMEOUT_EN

Behaviour:
- Reset values: all outputs 0 except o_window_ready=1 and o_reject_stage=3. Accumulator, stage, index and coordinates are cleared. FSM goes to IDLE.
- FSM states: IDLE, ISSUE, WAIT, CHECK, REPORT.
- IDLE
  - o_window_ready=1.
  - On valid&ready: latch coords; stage=0, idx=0, acc=0; go to ISSUE.
- ISSUE: assert o_eval_start for exactly 1 cycle with a stable stage_sel/index; go to WAIT.
- WAIT
  - On i_eval_done: acc = sat(acc + score). The sum saturates to the signed ACC_WIDTH min/max.
  - If idx == N(stage)-1, go to CHECK; else idx++ and go to ISSUE.
  - i_eval_done is ignored in every other state.
- CHECK (1 cycle): signed compare acc >= i_stage_threshold.
  - Fail: verdict=0, reject_stage=stage, go to REPORT.
  - Pass and stage==2: verdict=1, reject_stage=3, go to REPORT.
  - Pass otherwise: stage++, idx=0, acc=0, go to ISSUE.
- REPORT
  - o_candidate_valid=1 for 1 cycle, with o_is_candidate, o_reject_stage and coords.
  - Then go to IDLE. Verdict, reject_stage and coords hold until the next REPORT.
- o_window_ready=0 and o_busy=1 in every state except IDLE.
  - i_window_valid asserted while busy is not consumed. The source must hold it.
- Latency: with a 1-cycle eval_done, a window that passes all stages takes 2*(N0+N1+N2)+3+1 cycles from acceptance to strobe.
  - A stage-0 reject takes 2*N0+2 cycles.
- Back-to-back windows: the next window is accepted in the IDLE cycle after REPORT, so there is no bubble beyond that cycle.
- Reset mid-operation: returns to IDLE the next edge. Any in-flight evaluation result is discarded and no verdict strobe is emitted.

Optional Feature:
CASCADE_EVAL_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT.
  - If it reaches TIMEOUT_CYCLES with no i_eval_done, the window is aborted.
  - REPORT is entered with verdict=0, reject_stage=current stage, and o_timeout=1 for the strobe cycle.
  - The counter clears on ISSUE.
- Undefined: no counter and no o_timeout port. WAIT waits indefinitely.

Decomposition:
- Package face_detect_pkg:
  - FSM state enum
  - STAGE_FIRST/SECOND/THIRD = 0/1/2 and STAGE_NONE = 3
  - NUM_STAGES = 3
  - saturation min/max constants derived from ACC_WIDTH
- Sub-module sat_accumulator: signed saturating add with clear and enable.

Test Plan:
- All scores +5, thresholds 50/50/50, N=10/10/10, eval_done 1 cycle after start, window (12,34) -> one strobe after 64 cycles: o_is_candidate=1, reject_stage=3, coords 12/34; exactly 30 eval_start pulses.
- Stage-1 scores +1 with threshold 50 -> strobe with o_is_candidate=0, reject_stage=1; 20 eval_start pulses; stage 2 is never selected.
- Scores 0x7FFF x10 -> acc saturates at 32767 (no wrap); threshold 32767 passes.
- i_window_valid held high across two windows -> exactly one acceptance per IDLE cycle; the second window's coords appear only on the second strobe.
- Reset asserted for 1 cycle in WAIT at stage 1 -> next cycle IDLE, ready=1, no strobe; a late i_eval_done is ignored.
- CASCADE_EVAL_TIMEOUT_EN, i_eval_done never asserted -> strobe 255 cycles after WAIT entry: o_timeout=1, o_is_candidate=0, reject_stage=0.
